retire_trace_buffer: RTL

//  Synthesisable retirement monitor for the CPU, parametrised in depth, widths and overflow mode.

---
 rtl/retire_trace_buffer.sv | 92 +++++++++
 1 files changed

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: logs {seq, pc, rd, wdata} on each fetch-enable rising edge into an FWFT FIFO
module retire_trace_buffer #(
    parameter int PC_W      = 32,
    parameter int REG_AW    = 5,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_stage_enable,
    input  logic [PC_W-1:0]            program_counter,
    input  logic [REG_AW-1:0]          write_reg,
    input  logic [DATA_W-1:0]          write_data,
    input  logic                       capture_en,
    input  logic                       rd_filter_en,
    input  logic [REG_AW-1:0]          rd_filter,
    input  logic                       clear,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [15:0]                trace_seq,
    output logic [PC_W-1:0]            trace_pc,
    output logic [REG_AW-1:0]          trace_rd,
    output logic [DATA_W-1:0]          trace_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    output logic [15:0]                drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic              fetch_d;
    logic [15:0]       seq;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [15:0]       seq_mem  [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [REG_AW-1:0] rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic              ev, push, pop, wr_en, rd_adv, drop;
    assign ev          = fetch_stage_enable & ~fetch_d & capture_en;
    assign push        = ev & (~rd_filter_en | (write_reg == rd_filter)) & ~clear;
    assign trace_valid = count != '0;
    assign full        = count == CW'(DEPTH);
    assign pop         = trace_valid & trace_ready & ~clear;
    // a full FIFO still accepts a push when it pops the same cycle, or when evicting the oldest
    assign wr_en       = push & (~full | pop | (OVERWRITE != 0));
    assign rd_adv      = pop | (wr_en & full);
    assign drop        = push & full & ~pop;
    // head fields are forced to zero while empty so reset/cleared state reads as zero
    assign trace_seq   = trace_valid ? seq_mem[rd_ptr]  : '0;
    assign trace_pc    = trace_valid ? pc_mem[rd_ptr]   : '0;
    assign trace_rd    = trace_valid ? rd_mem[rd_ptr]   : '0;
    assign trace_data  = trace_valid ? data_mem[rd_ptr] : '0;
    // control state: edge detect, sequence counter, pointers, occupancy and loss accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_d    <= 1'b1;
            seq        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            fetch_d <= fetch_stage_enable;
            if (clear) begin
                seq        <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                overflow   <= 1'b0;
                drop_count <= '0;
            end else begin
                if (ev) seq <= seq + 16'd1;
                if (wr_en) wr_ptr <= wr_ptr + AW'(1);
                if (rd_adv) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(wr_en) - CW'(rd_adv);
                if (drop) overflow <= 1'b1;
                if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
        end
    end
    // record storage, written at the event edge
    always_ff @(posedge clk) begin
        if (wr_en) begin
            seq_mem[wr_ptr]  <= seq;
            pc_mem[wr_ptr]   <= program_counter;
            rd_mem[wr_ptr]   <= write_reg;
            data_mem[wr_ptr] <= write_data;
        end
    end
endmodule
